// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types and constants for the UART receive path.
//   rx_state_e  - receiver FSM state encoding
//   DATA_W      - payload width of one frame
//   SYNC_STAGES - depth of the rx input synchronizer
// Optional feature macro: UART_RX_PARITY_EN (adds the PARITY state, 8E1 frames).
package uart_rx_pkg;

  localparam int DATA_W      = 8;
  localparam int SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core: synchronizes rx, deserializes 8N1 (or 8E1 with
// UART_RX_PARITY_EN) frames and emits one registered tick per good byte.
// Ports:
//   UART_clk, rst_n (async low)  - clock / reset
//   rx                           - asynchronous serial line, idle high
//   rx_enable                    - gates the start of new frames only
//   rx_byte                      - last deserialized byte, stable during rx_done_tick
//   rx_done_tick                 - one-cycle pulse, byte ready to push
//   frame_error, parity_error    - one-cycle pulses at the stop-bit decision
module uart_rx_core
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              UART_clk,
  input  logic              rst_n,
  input  logic              rx,
  input  logic              rx_enable,
  output logic [DATA_W-1:0] rx_byte,
  output logic              rx_done_tick,
  output logic              frame_error,
  output logic              parity_error
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  logic [SYNC_STAGES-1:0] sync;
  logic                   rx_s;
  rx_state_e              state, state_nxt;
  logic [CNT_W-1:0]       cnt;
  logic [2:0]             bit_idx;
  logic [DATA_W-1:0]      shift;
  logic                   armed;
  logic                   par_bad;
  logic                   half_hit, bit_hit;
  logic                   done_nxt, ferr_nxt, perr_nxt;

  assign rx_s     = sync[SYNC_STAGES-1];
  assign half_hit = (cnt == CNT_W'(CLKS_PER_BIT/2 - 1));
  assign bit_hit  = (cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign rx_byte  = shift;

  // state register
  always_ff @(posedge UART_clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (armed && !rx_s && rx_enable) state_nxt = ST_START;
      ST_START: if (half_hit) state_nxt = rx_s ? ST_IDLE : ST_DATA;
`ifdef UART_RX_PARITY_EN
      ST_DATA:   if (bit_hit && bit_idx == 3'd7) state_nxt = ST_PARITY;
      ST_PARITY: if (bit_hit) state_nxt = ST_STOP;
`else
      ST_DATA:   if (bit_hit && bit_idx == 3'd7) state_nxt = ST_STOP;
`endif
      ST_STOP:  if (bit_hit) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // output decisions, all taken at the stop-bit sample
  always_comb begin
    done_nxt = 1'b0;
    ferr_nxt = 1'b0;
    perr_nxt = 1'b0;
    if (state == ST_STOP && bit_hit) begin
      ferr_nxt = !rx_s;
      perr_nxt = par_bad;
      done_nxt = rx_s && !par_bad;
    end
  end

  // datapath: synchronizer, counters, shift register, arming
  always_ff @(posedge UART_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= '1;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      armed   <= 1'b1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], rx};
      // counter restarts on every state change and at each bit boundary
      if (state == ST_IDLE || state_nxt != state || bit_hit) cnt <= '0;
      else                                                  cnt <= cnt + CNT_W'(1);
      if (state != ST_DATA)  bit_idx <= '0;
      else if (bit_hit)      bit_idx <= bit_idx + 3'd1;
      if (state == ST_DATA && bit_hit) shift <= {rx_s, shift[DATA_W-1:1]};
      // a low stop bit disarms; line must be seen high before the next start
      if (state == ST_STOP && bit_hit && !rx_s) armed <= 1'b0;
      else if (rx_s)                            armed <= 1'b1;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge UART_clk or negedge rst_n) begin
    if (!rst_n)                            par_bad <= 1'b0;
    else if (state == ST_IDLE)             par_bad <= 1'b0;
    else if (state == ST_PARITY && bit_hit) par_bad <= rx_s ^ (^shift);
  end
`else
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge UART_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_done_tick <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      rx_done_tick <= done_nxt;
      frame_error  <= ferr_nxt;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge UART_clk or negedge rst_n) begin
    if (!rst_n) parity_error <= 1'b0;
    else        parity_error <= perr_nxt;
  end
`else
  assign parity_error = 1'b0;
`endif

endmodule

// File: rtl/uart_rx_wrapper.sv
// uart_rx_wrapper: UART receiver plus receive FIFO drained by the host.
// Optional feature macro: UART_RX_PARITY_EN (8E1 frames, parity_error live).
// Ports:
//   UART_clk, rst_n (async low) - clock / reset
//   rx, rx_enable               - serial line and new-frame enable
//   rd_en                       - pop one byte
//   data_out, rd_ack            - popped byte, valid when rd_ack pulses
//   empty, full                 - FIFO status
//   overflow, underflow         - one-cycle pulses: byte dropped / pop while empty
//   frame_error, parity_error   - one-cycle receive error pulses
module uart_rx_wrapper
  import uart_rx_pkg::*;
#(
  parameter int FIFO_DEPTH   = 16,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              UART_clk,
  input  logic              rst_n,
  input  logic              rx,
  input  logic              rx_enable,
  input  logic              rd_en,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_ack,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow,
  output logic              frame_error,
  output logic              parity_error
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] rx_byte;
  logic              rx_done_tick;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              do_wr, do_rd;

  uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_core (
    .UART_clk     (UART_clk),
    .rst_n        (rst_n),
    .rx           (rx),
    .rx_enable    (rx_enable),
    .rx_byte      (rx_byte),
    .rx_done_tick (rx_done_tick),
    .frame_error  (frame_error),
    .parity_error (parity_error)
  );

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(FIFO_DEPTH));
  assign do_rd = rd_en && !empty;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts
  assign do_wr = rx_done_tick && (!full || do_rd);

  always_ff @(posedge UART_clk) begin
    if (do_wr) mem[wr_ptr] <= rx_byte;
  end

  always_ff @(posedge UART_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      data_out  <= '0;
      rd_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) begin
        rd_ptr   <= rd_ptr + AW'(1);
        data_out <= mem[rd_ptr];
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      rd_ack    <= do_rd;
      overflow  <= rx_done_tick && full && !rd_en;
      underflow <= rd_en && empty;
    end
  end

endmodule
